// File: rtl/o_ddr_cell_pkg.sv
// Shared constants for the output DDR cell: word width and the value every
// register in the cell takes while reset is asserted.
package o_ddr_cell_pkg;

  // Two bits per clock: bit 0 leaves in the C-high phase, bit 1 in the C-low phase.
  localparam int WORD_W = 2;

  // Value held by all state while R=1 and until the first enabled edge after release.
  localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/o_ddr_negreg.sv
// Falling-edge register of the output DDR cell.
// Kept in its own module so the opposite-edge flop can be constrained on its own.
module o_ddr_negreg
  import o_ddr_cell_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Capture on the falling edge when enabled; asynchronous clear to the reset value.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/o_ddr_cell.sv
// Output double-data-rate cell. A 2-bit word is captured on each rising edge of C;
// Q carries D[0] while C is high and D[1] during the following low phase.
// The low-phase bit is retimed onto the falling edge so it is stable for the
// whole low phase, and the output is a plain mux on C with no extra register.
module o_ddr_cell
  import o_ddr_cell_pkg::*;
(
  input  logic              C,
  input  logic              R,
  input  logic [WORD_W-1:0] D,
  input  logic              E,
  output logic              Q
);

  logic [WORD_W-1:0] pos_q;
  logic              neg_q;

  // Rising-edge capture of the parallel word; hold when E=0, async clear on R.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      pos_q <= {WORD_W{RST_VAL}};
    end else if (E) begin
      pos_q <= D;
    end
  end

  // Falling-edge retime of the low-phase bit.
  o_ddr_negreg u_negreg (
    .clk (C),
    .rst (R),
    .en  (E),
    .d   (pos_q[1]),
    .q   (neg_q)
  );

  // Phase select: high phase drives the captured bit 0, low phase the retimed bit 1.
  assign Q = C ? pos_q[0] : neg_q;

endmodule

// File: tb/tb_o_ddr_cell.sv
// Testbench for o_ddr_cell: directed phase checks plus a scoreboard that compares
// Q in every C phase against a behavioural model of the DDR output stream.
`timescale 1ns/1ps
module tb_o_ddr_cell;

  // ---------------- clock / reset ----------------
  logic       C = 1'b0;
  logic       R;
  logic [1:0] D;
  logic       E;
  logic       Q;

  always #5 C = ~C;

  o_ddr_cell dut (
    .C (C),
    .R (R),
    .D (D),
    .E (E),
    .Q (Q)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  // ---------------- reference model + scoreboard ----------------
  // The model keeps the last word accepted at an enabled rising edge and the
  // low-phase bit handed over at an enabled falling edge. At each edge it pushes
  // the value the pin must show for the phase that edge starts.
  logic [0:0] exp_q[$];
  logic [1:0] m_word = 2'b00;
  logic       m_low  = 1'b0;

  always @(posedge R) begin
    m_word = 2'b00;
    m_low  = 1'b0;
  end

  always @(posedge C) begin
    if (!R && E) m_word = D;
    if (mon_en) exp_q.push_back(R ? 1'b0 : m_word[0]);
  end

  always @(negedge C) begin
    if (!R && E) m_low = m_word[1];
    if (mon_en) exp_q.push_back(R ? 1'b0 : m_low);
  end

  // Monitor: sample Q 2ns into each phase and compare with the oldest expectation.
  always @(posedge C or negedge C) begin
    logic exp_v;
    #2;
    if (mon_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: Q=%b but no expected value queued at %0t", Q, $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (Q !== exp_v) begin
          n_fail++;
          $display("FAIL sb_phase(C=%b): Q=%b expected=%b at %0t", C, Q, exp_v, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic exp_v);
    n_tests++;
    if (Q !== exp_v) begin
      n_fail++;
      $display("FAIL %s: Q=%b expected=%b at %0t", name, Q, exp_v, $time);
    end
  endtask

  // Called in a low phase: presents one word, checks both phases of the next
  // cycle, and returns 3ns after the falling edge.
  task automatic step(input string name, input logic [1:0] d, input logic e,
                      input logic exp_hi, input logic exp_lo);
    D = d;
    E = e;
    @(posedge C); #2;
    check({name, "_hi"}, exp_hi);
    @(negedge C); #2;
    check({name, "_lo"}, exp_lo);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    R = 1'b1;
    D = 2'b11;
    E = 1'b1;

    // Reset held with active data and enable: pin stays low in both phases.
    repeat (2) begin
      @(posedge C); #2; check("rst_hi", 1'b0);
      @(negedge C); #2; check("rst_lo", 1'b0);
    end

    // Release in the high phase: the falling edge comes first and loads 0.
    @(posedge C); #3;
    R = 1'b0;
    #0 check("rel_hi", 1'b0);
    @(negedge C); #2; check("rel_lo", 1'b0);
    #1;
    step("first_rise", 2'b11, 1'b1, 1'b1, 1'b1);

    mon_en = 1'b1;

    // Directed stream.
    step("s01", 2'b01, 1'b1, 1'b1, 1'b0);
    step("s10", 2'b10, 1'b1, 1'b0, 1'b1);
    step("s11", 2'b11, 1'b1, 1'b1, 1'b1);
    step("s00", 2'b00, 1'b1, 1'b0, 1'b0);

    // Enable hold: the held word keeps toggling out while D changes.
    step("ld10", 2'b10, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("hold", 2'b01, 1'b0, 1'b0, 1'b1);
    step("reen", 2'b01, 1'b1, 1'b1, 1'b0);

    // Mid-operation reset during a low phase showing 1.
    mon_en = 1'b0;
    D = 2'b10;
    E = 1'b1;
    @(posedge C); #2; check("pre_rst_hi", 1'b0);
    @(negedge C); #1; check("pre_rst_lo", 1'b1);
    R = 1'b1;
    #1 check("mid_rst", 1'b0);
    #1 R = 1'b0;
    D = 2'b11;
    E = 1'b0;
    #1 check("post_rst", 1'b0);
    @(posedge C); #2; check("post_rst_hi", 1'b0);
    @(negedge C); #2; check("post_rst_lo", 1'b0);
    #1;
    step("after_rst", 2'b01, 1'b1, 1'b1, 1'b0);
    mon_en = 1'b1;

    // Random words, enable held high; the scoreboard checks every phase.
    for (int i = 0; i < 20; i++) begin
      D = 2'($urandom_range(0, 3));
      E = 1'b1;
      @(negedge C); #3;
    end

    // Split enable: word taken at the rise, falling edge disabled.
    step("zero", 2'b00, 1'b1, 1'b0, 1'b0);
    D = 2'b11;
    E = 1'b1;
    @(posedge C); #2; check("split_hi", 1'b1);
    #1 E = 1'b0;
    @(negedge C); #2; check("split_lo", 1'b0);
    #1;
    mon_en = 1'b0;

    // Every queued expectation must have been consumed.
    @(posedge C); #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
